operand_fetch: RTL and testbench



---
 rtl/operand_fetch_pkg.sv | 23 ++
 rtl/operand_fetch_scoreboard.sv | 30 +++
 rtl/operand_fetch.sv | 67 ++++++
 tb/tb_operand_fetch.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// of_pkg: shared widths, register/word types and request/response structs for operand_fetch
package of_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW = $clog2(NREG);
  localparam int OPW = 8;
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;
  typedef struct packed {
    reg_addr_t rs0;
    reg_addr_t rs1;
    reg_addr_t rd;
    logic wen;
    logic [OPW-1:0] op;
  } of_req_t;
  typedef struct packed {
    xword_t op0;
    xword_t op1;
    reg_addr_t rd;
    logic wen;
    logic [OPW-1:0] op;
  } of_rsp_t;
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// operand_fetch_scoreboard: per-register pending-write bits; set/clear ports, three writeback-aware busy queries, err pulse on clear of an idle register
module operand_fetch_scoreboard
  import of_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t q0_addr,
  input  reg_addr_t q1_addr,
  input  reg_addr_t q2_addr,
  output logic      eff_busy0,
  output logic      eff_busy1,
  output logic      eff_busy2,
  output logic      err
);
  logic [NREG-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    eff_busy0 = busy_q[q0_addr] && !(clr_en && clr_addr == q0_addr);
    eff_busy1 = busy_q[q1_addr] && !(clr_en && clr_addr == q1_addr);
    eff_busy2 = busy_q[q2_addr] && !(clr_en && clr_addr == q2_addr);
    err = clr_en && !busy_q[clr_addr];
  end
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: issue stage; in_* handshake, rf_* read ports with writeback bypass, wb_* writeback, out_* registered operands, sb_err sticky scoreboard error
module operand_fetch
  import of_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs0,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_wen,
  input  logic [OPW-1:0]  in_op,
  output logic [AW-1:0]   rf_ra0,
  output logic [AW-1:0]   rf_ra1,
  input  logic [XLEN-1:0] rf_rd0,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op0,
  output logic [XLEN-1:0] out_op1,
  output logic [AW-1:0]   out_rd,
  output logic            out_wen,
  output logic [OPW-1:0]  out_op,
  output logic            sb_err
);
  of_req_t req;
  of_rsp_t rsp_q, rsp_d;
  logic out_valid_q, out_valid_d, sb_err_q, sb_err_d;
  logic b0, b1, b2, err, hazard, accept;
  xword_t op0_sel, op1_sel;
  operand_fetch_scoreboard u_sb (
    .clk(clk), .rst(rst),
    .set_en(accept && req.wen), .set_addr(req.rd),
    .clr_en(wb_valid), .clr_addr(wb_wa),
    .q0_addr(req.rs0), .q1_addr(req.rs1), .q2_addr(req.rd),
    .eff_busy0(b0), .eff_busy1(b1), .eff_busy2(b2), .err(err)
  );
  always_comb begin
    req = '{rs0: in_rs0, rs1: in_rs1, rd: in_rd, wen: in_wen, op: in_op};
    op0_sel = (wb_valid && wb_wa == req.rs0) ? wb_wd : rf_rd0;
    op1_sel = (wb_valid && wb_wa == req.rs1) ? wb_wd : rf_rd1;
    hazard = in_valid && (b0 || b1 || (req.wen && b2));
    in_ready = !rst && !hazard && (!out_valid_q || out_ready);
    accept = in_valid && in_ready;
    rsp_d = accept ? '{op0: op0_sel, op1: op1_sel, rd: req.rd, wen: req.wen, op: req.op} : rsp_q;
    out_valid_d = accept || (out_valid_q && !out_ready);
    sb_err_d = sb_err_q || err;
  end
  always_ff @(posedge clk) begin
    rsp_q <= rst ? '0 : rsp_d;
    out_valid_q <= rst ? 1'b0 : out_valid_d;
    sb_err_q <= rst ? 1'b0 : sb_err_d;
  end
  assign rf_ra0 = in_rs0;
  assign rf_ra1 = in_rs1;
  assign out_valid = out_valid_q;
  assign out_op0 = rsp_q.op0;
  assign out_op1 = rsp_q.op1;
  assign out_rd = rsp_q.rd;
  assign out_wen = rsp_q.wen;
  assign out_op = rsp_q.op;
  assign sb_err = sb_err_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench for operand_fetch with a behavioural regfile
module tb_operand_fetch;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_wen = 1'b0, wb_valid = 1'b0, out_valid, out_ready = 1'b1, out_wen, sb_err;
  logic [4:0] in_rs0 = '0, in_rs1 = '0, in_rd = '0, rf_ra0, rf_ra1, wb_wa = '0, out_rd;
  logic [7:0] in_op = '0, out_op;
  logic [63:0] rf_rd0, rf_rd1, wb_wd = '0, out_op0, out_op1;
  logic [63:0] rf [32];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (wb_valid) rf[wb_wa] <= wb_wd;
  assign rf_rd0 = rf[rf_ra0];
  assign rf_rd1 = rf[rf_ra1];
  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd), .in_wen(in_wen), .in_op(in_op),
    .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
    .wb_valid(wb_valid), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_op0(out_op0), .out_op1(out_op1),
    .out_rd(out_rd), .out_wen(out_wen), .out_op(out_op), .sb_err(sb_err)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rd, input logic wen, input logic [7:0] op);
    in_valid = 1'b1; in_rs0 = rs0; in_rs1 = rs1; in_rd = rd; in_wen = wen; in_op = op;
  endtask
  task automatic idle();
    in_valid = 1'b0; in_wen = 1'b0; wb_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_op0 !== 64'h0 || out_op !== 8'h0) begin errors++; $display("FAIL reset_out_data got %h/%h exp 0", out_op0, out_op); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got %b exp 0", sb_err); end
    checks++; if (dut.u_sb.busy_q !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", dut.u_sb.busy_q); end
  endtask
  task automatic test_basic();
    issue(5'd3, 5'd4, 5'd0, 1'b0, 8'h01);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", in_ready); end
    step(); idle(); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    checks++; if (out_op0 !== 64'h11 || out_op1 !== 64'h22) begin errors++; $display("FAIL basic_ops got %h/%h exp 11/22", out_op0, out_op1); end
    checks++; if (dut.u_sb.busy_q !== 32'h0) begin errors++; $display("FAIL basic_busy got %h exp 0", dut.u_sb.busy_q); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid); end
  endtask
  task automatic test_bypass();
    issue(5'd0, 5'd0, 5'd5, 1'b1, 8'h02);
    step();
    issue(5'd5, 5'd5, 5'd0, 1'b0, 8'h03);
    wb_valid = 1'b1; wb_wa = 5'd5; wb_wd = 64'h1BB;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got %b exp 1", in_ready); end
    step(); idle(); #1;
    checks++; if (out_op0 !== 64'h1BB || out_op1 !== 64'h1BB) begin errors++; $display("FAIL bypass_ops got %h/%h exp 1bb/1bb", out_op0, out_op1); end
    checks++; if (dut.u_sb.busy_q[5] !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL bypass_sb got busy %b err %b exp 0 0", dut.u_sb.busy_q[5], sb_err); end
    step();
  endtask
  task automatic test_raw();
    issue(5'd0, 5'd0, 5'd7, 1'b1, 8'h04);
    step();
    issue(5'd7, 5'd0, 5'd0, 1'b0, 8'h05);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall%0d got %b exp 0", i, in_ready); end
      step();
    end
    wb_valid = 1'b1; wb_wa = 5'd7; wb_wd = 64'h55;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", in_ready); end
    step(); idle(); #1;
    checks++; if (out_valid !== 1'b1 || out_op0 !== 64'h55 || out_op !== 8'h05) begin errors++; $display("FAIL raw_out got v %b op0 %h op %h exp 1 55 05", out_valid, out_op0, out_op); end
    checks++; if (dut.u_sb.busy_q[7] !== 1'b0) begin errors++; $display("FAIL raw_busy7 got %b exp 0", dut.u_sb.busy_q[7]); end
    step();
  endtask
  task automatic test_waw();
    issue(5'd0, 5'd0, 5'd9, 1'b1, 8'h06);
    step();
    issue(5'd1, 5'd1, 5'd9, 1'b1, 8'h07);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got %b exp 0", in_ready); end
    step();
    wb_valid = 1'b1; wb_wa = 5'd9; wb_wd = 64'h99;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_release got %b exp 1", in_ready); end
    step(); idle(); #1;
    checks++; if (dut.u_sb.busy_q[9] !== 1'b1 || sb_err !== 1'b0) begin errors++; $display("FAIL waw_collision got busy %b err %b exp 1 0", dut.u_sb.busy_q[9], sb_err); end
    checks++; if (out_rd !== 5'd9 || out_wen !== 1'b1 || out_op !== 8'h07) begin errors++; $display("FAIL waw_out got rd %0d wen %b op %h exp 9 1 07", out_rd, out_wen, out_op); end
    wb_valid = 1'b1; wb_wa = 5'd9; wb_wd = 64'h9A;
    step(); idle(); #1;
    checks++; if (dut.u_sb.busy_q !== 32'h0) begin errors++; $display("FAIL waw_clear got %h exp 0", dut.u_sb.busy_q); end
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(5'd3, 5'd4, 5'd0, 1'b0, 8'h5A);
    step();
    issue(5'd4, 5'd3, 5'd0, 1'b0, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_hs%0d got rdy %b v %b exp 0 1", i, in_ready, out_valid); end
      checks++; if (out_op0 !== 64'h11 || out_op1 !== 64'h22 || out_op !== 8'h5A) begin errors++; $display("FAIL bp_hold_data%0d got %h/%h/%h exp 11/22/5a", i, out_op0, out_op1, out_op); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %b exp 1", in_ready); end
    step(); idle(); #1;
    checks++; if (out_valid !== 1'b1 || out_op !== 8'hA5 || out_op0 !== 64'h22 || out_op1 !== 64'h11) begin errors++; $display("FAIL bp_next got v %b op %h %h/%h exp 1 a5 22/11", out_valid, out_op, out_op0, out_op1); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single got %b exp 0", out_valid); end
  endtask
  task automatic test_back_to_back();
    issue(5'd10, 5'd11, 5'd0, 1'b0, 8'h10);
    step();
    issue(5'd11, 5'd12, 5'd0, 1'b0, 8'h11);
    #1;
    checks++; if (in_ready !== 1'b1 || out_op0 !== 64'h1000 || out_op1 !== 64'h2000 || out_op !== 8'h10) begin errors++; $display("FAIL b2b_0 got rdy %b %h/%h op %h", in_ready, out_op0, out_op1, out_op); end
    step();
    issue(5'd12, 5'd10, 5'd0, 1'b0, 8'h12);
    #1;
    checks++; if (in_ready !== 1'b1 || out_op0 !== 64'h2000 || out_op1 !== 64'h3000 || out_op !== 8'h11) begin errors++; $display("FAIL b2b_1 got rdy %b %h/%h op %h", in_ready, out_op0, out_op1, out_op); end
    step(); idle(); #1;
    checks++; if (out_valid !== 1'b1 || out_op0 !== 64'h3000 || out_op1 !== 64'h1000 || out_op !== 8'h12) begin errors++; $display("FAIL b2b_2 got v %b %h/%h op %h", out_valid, out_op0, out_op1, out_op); end
    step();
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd2, 1'b1, 8'h20);
    step(); idle(); #1;
    checks++; if (out_valid !== 1'b1 || dut.u_sb.busy_q[2] !== 1'b1) begin errors++; $display("FAIL rm_pre got v %b busy2 %b exp 1 1", out_valid, dut.u_sb.busy_q[2]); end
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (dut.u_sb.busy_q !== 32'h0 || out_valid !== 1'b0 || sb_err !== 1'b0 || out_op !== 8'h0) begin errors++; $display("FAIL rm_after got busy %h v %b err %b op %h exp 0", dut.u_sb.busy_q, out_valid, sb_err, out_op); end
    wb_valid = 1'b1; wb_wa = 5'd2; wb_wd = 64'h22;
    step(); idle(); #1;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sb_err_set got %b exp 1", sb_err); end
    step(); step(); step();
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sb_err_sticky got %b exp 1", sb_err); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sb_err_reset got %b exp 0", sb_err); end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'h0;
    rf[3] = 64'h11; rf[4] = 64'h22; rf[5] = 64'hAA;
    rf[10] = 64'h1000; rf[11] = 64'h2000; rf[12] = 64'h3000;
    test_reset();
    test_basic();
    test_bypass();
    test_raw();
    test_waw();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
